// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: flit-type encoding, grant FSM states and default widths shared by the packet path.
package ravenoc_pkg;
  localparam int N_INPUTS_DEF = 4;
  localparam int FLIT_WIDTH_DEF = 34;
  typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_t;
  typedef enum logic {IDLE, LOCKED} state_t;
  // The type field always occupies the two most significant bits of a flit.
  function automatic logic is_head(logic [1:0] t);
    return t == HEAD || t == HEAD_TAIL;
  endfunction
  function automatic logic is_tail(logic [1:0] t);
    return t == TAIL || t == HEAD_TAIL;
  endfunction
endpackage

// File: rtl/flit_out_reg.sv
// flit_out_reg: single-entry valid/ready pipeline register, full throughput with hold on stall.
module flit_out_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] data,
  output logic         valid,
  input  logic         out_ready
);
  logic load;
  assign in_ready = !valid || out_ready;
  assign load = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data <= in_data;
      valid <= 1'b1;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end
  a_hold: assert property (@(posedge clk) disable iff (rst) valid && !out_ready |=> valid && $stable(data));
endmodule

// File: rtl/pkt_grant_ctrl.sv
// pkt_grant_ctrl: locks onto the arbiter-granted input for one whole packet and forwards its flits.
// Priority advances via update_o when the packet's tail is accepted.
module pkt_grant_ctrl
  import ravenoc_pkg::*;
#(
  parameter int N_OF_INPUTS = N_INPUTS_DEF,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic [N_OF_INPUTS*FLIT_WIDTH-1:0] in_flit_i,
  input  logic [N_OF_INPUTS-1:0]            in_valid_i,
  output logic [N_OF_INPUTS-1:0]            in_ready_o,
  output logic [N_OF_INPUTS-1:0]            req_o,
  input  logic [N_OF_INPUTS-1:0]            grant_i,
  output logic                              update_o,
  output logic [FLIT_WIDTH-1:0]             out_flit_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic                              pkt_err_o
);
  localparam int SW = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;
  state_t state, next_state;
  logic [SW-1:0] sel, next_sel, gidx;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic [1:0] sel_type;
  logic locked, idle, grant_ok, sel_valid, sel_ready, load;
  // Combinational outputs are forced low while reset is held, not just after the edge.
  assign locked = state == LOCKED && !arst;
  assign idle = state == IDLE && !arst;
  assign sel_flit = in_flit_i[sel*FLIT_WIDTH +: FLIT_WIDTH];
  assign sel_type = sel_flit[FLIT_WIDTH-1 -: 2];
  assign sel_valid = locked && in_valid_i[sel];
  assign load = sel_valid && sel_ready;
  assign update_o = load && is_tail(sel_type);
  assign in_ready_o = locked ? N_OF_INPUTS'(sel_ready) << sel : '0;
  assign grant_ok = idle && $onehot(grant_i) && |(grant_i & req_o);
  always_comb begin
    req_o = '0;
    gidx = '0;
    for (int i = 0; i < N_OF_INPUTS; i++) begin
      req_o[i] = idle && in_valid_i[i] && is_head(in_flit_i[i*FLIT_WIDTH + FLIT_WIDTH-1 -: 2]);
      if (grant_i[i]) gidx = SW'(i);
    end
  end
  always_comb begin
    next_state = state;
    next_sel = sel;
    if (grant_ok) begin
      next_state = LOCKED;
      next_sel = gidx;
    end else if (update_o) begin
      next_state = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      sel <= '0;
      pkt_err_o <= 1'b0;
    end else begin
      state <= next_state;
      sel <= next_sel;
      pkt_err_o <= pkt_err_o || (load && sel_type == HEAD);
    end
  end
  flit_out_reg #(.W(FLIT_WIDTH)) u_out (
    .clk(clk),
    .rst(arst),
    .in_data(sel_flit),
    .in_valid(sel_valid),
    .in_ready(sel_ready),
    .data(out_flit_o),
    .valid(out_valid_o),
    .out_ready(out_ready_i)
  );
  a_grant: assert property (@(posedge clk) disable iff (arst) $onehot0(grant_i));
endmodule

// File: doc/pkt_grant_ctrl.md
PKT_GRANT_CTRL -- requirements
Module: pkt_grant_ctrl

Interface
REQ-001 The block SHALL have these parameters: N_OF_INPUTS, default 4, number of input flit ports; FLIT_WIDTH, default 34, flit width in bits, with bits [FLIT_WIDTH-1:FLIT_WIDTH-2] holding the flit type.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 arst  input  1  reset, synchronous and active-high.
REQ-004 in_flit_i  input  N_OF_INPUTS x FLIT_WIDTH  flit offered by each input port.
REQ-005 in_valid_i  input  N_OF_INPUTS  per-port flit valid.
REQ-006 in_ready_o  output  N_OF_INPUTS  per-port flit accepted; at most one bit high at a time.
REQ-007 req_o  output  N_OF_INPUTS  request vector driven to the external round-robin arbiter.
REQ-008 grant_i  input  N_OF_INPUTS  grant from the arbiter; one-hot or zero, combinational from req_o.
REQ-009 update_o  output  1  single-cycle pulse that advances the arbiter priority pointer.
REQ-010 out_flit_o  output  FLIT_WIDTH  registered output flit.
REQ-011 out_valid_o  output  1  output flit valid.
REQ-012 out_ready_i  input  1  downstream accepts the output flit.
REQ-013 pkt_err_o  output  1  sticky protocol-error flag.

Function
REQ-014 Flit type encoding SHALL be: HEAD 2'b00, BODY 2'b01, TAIL 2'b10, HEAD_TAIL 2'b11.
REQ-015 The FSM SHALL have two states: IDLE and LOCKED.
REQ-016 In IDLE, req_o[k] SHALL equal in_valid_i[k] AND (type is HEAD or HEAD_TAIL); in_ready_o SHALL be all zero.
REQ-017 In IDLE, if grant_i is one-hot and req_o is high at that bit, the block SHALL latch the port index into sel and move to LOCKED on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 A zero, multi-hot or non-requested grant_i SHALL be ignored.
REQ-019 In LOCKED, req_o SHALL be zero and only in_ready_o[sel] may be high; it SHALL equal (NOT out_valid_o) OR out_ready_i.
REQ-020 Each accepted flit (in_valid_i[sel] AND in_ready_o[sel]) SHALL be loaded into the output register and appear on out_flit_o with out_valid_o high on the next cycle (1-cycle latency, full throughput).
REQ-021 out_valid_o SHALL clear when out_ready_i is high and no new flit is loaded in the same cycle.
REQ-022 While out_valid_o is high and out_ready_i is low, out_flit_o and out_valid_o SHALL hold their values.
REQ-023 When a TAIL or HEAD_TAIL flit is accepted in LOCKED, update_o SHALL pulse high for exactly that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-024 update_o SHALL never be high in IDLE.
REQ-025 A HEAD flit accepted in LOCKED SHALL be forwarded unchanged and SHALL set pkt_err_o, which stays set until reset.
REQ-026 Back-to-back packets SHALL incur exactly one IDLE (arbitration) cycle between a tail acceptance and the next head acceptance.
REQ-027 Non-selected ports SHALL never be acknowledged, whatever their valid or type.

Reset
REQ-028 While arst is high the block SHALL enter IDLE, with out_valid_o=0, out_flit_o=0, update_o=0, in_ready_o=0, req_o=0, pkt_err_o=0 and sel=0.
REQ-029 A reset mid-packet SHALL discard the output register content and SHALL NOT pulse update_o.

Structure
REQ-030 The flit-type enum, type field position and default widths SHALL live in the shared ravenoc_pkg package.
REQ-031 The output register SHALL be one sub-module, flit_out_reg (single-entry valid/ready pipeline register); the arbiter stays external.
REQ-032 An assertion SHALL flag a multi-hot grant_i or a violation of output hold while stalled.

Verification
REQ-033 Single packet on port 2 (HEAD, BODY, TAIL, out_ready_i=1) -> req_o=4'b0100 in IDLE; three flits out in order, each 1 cycle after acceptance; update_o high once, on the TAIL cycle.
REQ-034 HEAD_TAIL on ports 0 and 3 simultaneously, arbiter pointer at 0 -> port 0 forwarded then update_o; after one IDLE cycle port 3 is granted and forwarded.
REQ-035 3-flit packet on port 1 with out_ready_i low for 5 cycles after the HEAD -> out_flit_o holds the HEAD, in_ready_o[1]=0 during the stall; no flit is lost or duplicated.
REQ-036 BODY flit offered on port 0 in IDLE -> req_o=0, in_ready_o=0, no output.
REQ-037 HEAD, HEAD, TAIL on port 2 -> the second HEAD is forwarded and pkt_err_o=1 until reset.
REQ-038 arst asserted after the BODY of a 3-flit packet -> next cycle IDLE, out_valid_o=0, update_o never pulsed.
